// File: rtl/tlb_mgmt_ctrl.sv
// tlb_mgmt_ctrl: sequences TLB maintenance ops (search/read/write/fill/invalidate)
// onto the tlb storage module over a single-outstanding valid/ready handshake.
package tlb_mgmt_pkg;
    typedef struct packed {
        logic        e;
        logic        g;
        logic [5:0]  ps;
        logic [9:0]  asid;
        logic [18:0] vpn;
        logic [19:0] ppn0;
        logic [19:0] ppn1;
    } tlb_entry_t;

    typedef struct packed {
        logic        clr_global;
        logic        clr_nonglobal;
        logic        check_asid;
        logic        check_vpn;
        logic [9:0]  asid;
        logic [18:0] vpn;
    } tlb_inv_req_t;
endpackage

module tlb_mgmt_ctrl
    import tlb_mgmt_pkg::*;
#(
    parameter int TLB_ENTRY_NUM = 16,
    localparam int IDXW = $clog2(TLB_ENTRY_NUM)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_valid_i,
    output logic                             req_ready_o,
    input  logic [2:0]                       req_op_i,
    input  logic [IDXW-1:0]                  req_index_i,
    input  tlb_entry_t                       req_entry_i,
    input  logic [4:0]                       req_inv_op_i,
    input  logic [9:0]                       req_asid_i,
    input  logic [18:0]                      req_vpn_i,
    input  tlb_entry_t [TLB_ENTRY_NUM-1:0]   entries_i,
    output logic                             tlb_we_o,
    output logic [IDXW-1:0]                  tlb_w_index_o,
    output tlb_entry_t                       tlb_w_entry_o,
    output tlb_inv_req_t                     tlb_inv_req_o,
    output logic                             resp_valid_o,
    output logic                             resp_hit_o,
    output logic [IDXW-1:0]                  resp_index_o,
    output tlb_entry_t                       resp_entry_o,
    output logic                             resp_bad_op_o
);
    typedef enum logic [2:0] {IDLE, SRCH, RDATA, WRITE, INV, RESP} state_e;

    state_e          state_q, state_d;
    logic [IDXW-1:0] index_q, index_d, fill_q, fill_d, rindex_q, rindex_d;
    tlb_entry_t      entry_q, entry_d, rentry_q, rentry_d;
    logic [4:0]      inv_op_q, inv_op_d;
    logic [9:0]      asid_q, asid_d;
    logic [18:0]     vpn_q, vpn_d;
    logic            hit_q, hit_d, bad_q, bad_d;
    logic            srch_hit;
    logic [IDXW-1:0] srch_idx;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        srch_hit = 1'b0;
        srch_idx = '0;
        for (int i = TLB_ENTRY_NUM - 1; i >= 0; i--)
            if (entries_i[i].e && (entries_i[i].g || entries_i[i].asid == asid_q) &&
                vpn_q[18:10] == entries_i[i].vpn[18:10] &&
                (entries_i[i].ps != 6'd12 || vpn_q[9:0] == entries_i[i].vpn[9:0])) begin
                srch_hit = 1'b1;
                srch_idx = IDXW'(i);
            end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            index_q  <= '0;
            fill_q   <= '0;
            rindex_q <= '0;
            entry_q  <= '0;
            rentry_q <= '0;
            inv_op_q <= '0;
            asid_q   <= '0;
            vpn_q    <= '0;
            hit_q    <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            fill_q   <= fill_d;
            rindex_q <= rindex_d;
            entry_q  <= entry_d;
            rentry_q <= rentry_d;
            inv_op_q <= inv_op_d;
            asid_q   <= asid_d;
            vpn_q    <= vpn_d;
            hit_q    <= hit_d;
            bad_q    <= bad_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        fill_d   = fill_q + 1'b1;
        rindex_d = rindex_q;
        entry_d  = entry_q;
        rentry_d = rentry_q;
        inv_op_d = inv_op_q;
        asid_d   = asid_q;
        vpn_d    = vpn_q;
        hit_d    = hit_q;
        bad_d    = bad_q;
        case (state_q)
            IDLE: if (req_valid_i) begin
                index_d  = req_op_i == 3'd3 ? fill_q : req_index_i;
                entry_d  = req_entry_i;
                inv_op_d = req_inv_op_i;
                asid_d   = req_asid_i;
                vpn_d    = req_vpn_i;
                bad_d    = req_op_i > 3'd4 ? 1'b1 : bad_q;
                state_d  = req_op_i == 3'd0 ? SRCH :
                           req_op_i == 3'd1 ? RDATA :
                           (req_op_i == 3'd2 || req_op_i == 3'd3) ? WRITE :
                           req_op_i == 3'd4 ? INV : RESP;
            end
            SRCH: begin
                hit_d    = srch_hit;
                rindex_d = srch_idx;
                bad_d    = 1'b0;
                state_d  = RESP;
            end
            RDATA: begin
                rentry_d = entries_i[index_q];
                rindex_d = index_q;
                bad_d    = 1'b0;
                state_d  = RESP;
            end
            WRITE: begin
                bad_d   = 1'b0;
                state_d = RESP;
            end
            INV: begin
                bad_d   = inv_op_q > 5'd5;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // Side-effect strobes are gated by rst_n so a reset drops them in the same cycle.
    always_comb begin
        req_ready_o   = state_q == IDLE;
        resp_valid_o  = state_q == RESP;
        resp_hit_o    = hit_q;
        resp_index_o  = rindex_q;
        resp_entry_o  = rentry_q;
        resp_bad_op_o = bad_q;
        tlb_we_o      = rst_n && state_q == WRITE;
        tlb_w_index_o = index_q;
        tlb_w_entry_o = entry_q;
        tlb_inv_req_o = '0;
        if (rst_n && state_q == INV && inv_op_q <= 5'd5) begin
            tlb_inv_req_o.clr_global    = inv_op_q <= 5'd2;
            tlb_inv_req_o.clr_nonglobal = inv_op_q != 5'd2;
            tlb_inv_req_o.check_asid    = inv_op_q >= 5'd4;
            tlb_inv_req_o.check_vpn     = inv_op_q == 5'd5;
            tlb_inv_req_o.asid          = asid_q;
            tlb_inv_req_o.vpn           = vpn_q;
        end
    end
endmodule

// File: tb/tb_tlb_mgmt_ctrl.sv
// tb_tlb_mgmt_ctrl: randomized bench with a behavioural tlb storage model and
// reference search/invalidate/fill-counter rules.
module tb_tlb_mgmt_ctrl;
    import tlb_mgmt_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0;
    logic req_ready;
    logic [2:0] req_op = '0;
    logic [3:0] req_index = '0;
    tlb_entry_t req_entry = '0;
    logic [4:0] req_inv_op = '0;
    logic [9:0] req_asid = '0;
    logic [18:0] req_vpn = '0;
    tlb_entry_t [15:0] entries;
    logic tlb_we;
    logic [3:0] tlb_w_index;
    tlb_entry_t tlb_w_entry;
    tlb_inv_req_t tlb_inv_req;
    logic resp_valid, resp_hit, resp_bad_op;
    logic [3:0] resp_index;
    tlb_entry_t resp_entry;

    int n_chk = 0;
    int n_fail = 0;

    tlb_entry_t mem [16] = '{default: '0};
    int fcnt = 0;
    int we_cnt = 0, inv_cnt = 0, rv_cnt = 0, both_cnt = 0;
    logic [3:0] w_idx = '0;
    tlb_entry_t w_ent = '0;
    tlb_inv_req_t inv_last = '0;
    int we0, inv0, fill_at;

    tlb_mgmt_ctrl #(.TLB_ENTRY_NUM(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_index_i(req_index), .req_entry_i(req_entry),
        .req_inv_op_i(req_inv_op), .req_asid_i(req_asid), .req_vpn_i(req_vpn),
        .entries_i(entries),
        .tlb_we_o(tlb_we), .tlb_w_index_o(tlb_w_index), .tlb_w_entry_o(tlb_w_entry),
        .tlb_inv_req_o(tlb_inv_req),
        .resp_valid_o(resp_valid), .resp_hit_o(resp_hit), .resp_index_o(resp_index),
        .resp_entry_o(resp_entry), .resp_bad_op_o(resp_bad_op)
    );

    always #5 clk = ~clk;

    always_comb for (int i = 0; i < 16; i++) entries[i] = mem[i];

    function automatic logic page_match(input tlb_entry_t m, input logic [18:0] vpn);
        return m.ps == 6'd12 ? m.vpn == vpn : m.vpn[18:10] == vpn[18:10];
    endfunction

    function automatic logic inv_kills(input tlb_entry_t m, input tlb_inv_req_t r);
        return (m.g ? r.clr_global : r.clr_nonglobal) &&
               (!r.check_asid || m.asid == r.asid) &&
               (!r.check_vpn || page_match(m, r.vpn));
    endfunction

    function automatic void ref_search(input logic [9:0] asid, input logic [18:0] vpn,
                                       output logic hit, output logic [3:0] idx);
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < 16; i++)
            if (!hit && mem[i].e && (mem[i].g || mem[i].asid == asid) && page_match(mem[i], vpn)) begin
                hit = 1'b1;
                idx = i[3:0];
            end
    endfunction

    function automatic tlb_inv_req_t exp_inv(input logic [4:0] op, input logic [9:0] asid,
                                            input logic [18:0] vpn);
        tlb_inv_req_t r = '0;
        r.asid = asid;
        r.vpn  = vpn;
        case (op)
            5'd0, 5'd1: begin r.clr_global = 1; r.clr_nonglobal = 1; end
            5'd2: r.clr_global = 1;
            5'd3: r.clr_nonglobal = 1;
            5'd4: begin r.clr_nonglobal = 1; r.check_asid = 1; end
            5'd5: begin r.clr_nonglobal = 1; r.check_asid = 1; r.check_vpn = 1; end
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic tlb_entry_t mk(input logic e, input logic g, input logic [5:0] ps,
                                      input logic [9:0] asid, input logic [18:0] vpn);
        tlb_entry_t t;
        t.e = e; t.g = g; t.ps = ps; t.asid = asid; t.vpn = vpn;
        t.ppn0 = 20'($urandom);
        t.ppn1 = 20'($urandom);
        return t;
    endfunction

    // Behavioural tlb storage plus event counters observed at the clock edge.
    always @(posedge clk) begin
        fcnt <= !rst_n ? 0 : (fcnt + 1) % 16;
        if (tlb_we) begin
            we_cnt <= we_cnt + 1;
            w_idx <= tlb_w_index;
            w_ent <= tlb_w_entry;
            mem[tlb_w_index] <= tlb_w_entry;
        end
        if (tlb_inv_req != '0) begin
            inv_cnt <= inv_cnt + 1;
            inv_last <= tlb_inv_req;
            for (int i = 0; i < 16; i++)
                if (inv_kills(mem[i], tlb_inv_req)) mem[i].e <= 1'b0;
        end
        if (tlb_we && tlb_inv_req != '0) both_cnt <= both_cnt + 1;
        if (resp_valid) rv_cnt <= rv_cnt + 1;
    end

    task automatic issue(input logic [2:0] op, input logic [3:0] idx, input tlb_entry_t ent,
                         input logic [4:0] iop, input logic [9:0] asid, input logic [18:0] vpn,
                         output int lat);
        @(negedge clk);
        n_chk++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_before_req: got %b expected 1", req_ready);
        end
        req_op = op; req_index = idx; req_entry = ent;
        req_inv_op = iop; req_asid = asid; req_vpn = vpn;
        req_valid = 1'b1;
        fill_at = fcnt; we0 = we_cnt; inv0 = inv_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = k;
                break;
            end
        end
        n_chk++;
        if (lat == 0) begin
            n_fail++;
            $display("FAIL resp_timeout: op %0d got no resp_valid within 8 cycles", op);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({req_ready, tlb_we, resp_valid, resp_hit, resp_bad_op} !== 5'b10000 || tlb_inv_req !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready/we/rv/hit/bad=%b inv=%h expected 10000 inv=0",
                     {req_ready, tlb_we, resp_valid, resp_hit, resp_bad_op}, tlb_inv_req);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_wr_srch();
        int lat;
        tlb_entry_t a = mk(1, 0, 12, 3, 19'h12345);
        issue(3'd2, 4'd5, a, 0, 0, 0, lat);
        n_chk++;
        if (lat != 2 || we_cnt - we0 != 1 || inv_cnt != inv0) begin
            n_fail++;
            $display("FAIL wr_pulse: lat %0d we %0d inv %0d expected 2 1 0", lat, we_cnt - we0, inv_cnt - inv0);
        end
        n_chk++;
        if (w_idx !== 4'd5 || w_ent !== a) begin
            n_fail++;
            $display("FAIL wr_data: idx %0d entry %h expected 5 %h", w_idx, w_ent, a);
        end
        issue(3'd0, 0, '0, 0, 10'd3, 19'h12345, lat);
        n_chk++;
        if (lat != 2 || resp_hit !== 1'b1 || resp_index !== 4'd5) begin
            n_fail++;
            $display("FAIL srch_hit: lat %0d hit %b idx %0d expected 2 1 5", lat, resp_hit, resp_index);
        end
        issue(3'd0, 0, '0, 0, 10'd4, 19'h12345, lat);
        n_chk++;
        if (resp_hit !== 1'b0 || resp_index !== 4'd0) begin
            n_fail++;
            $display("FAIL srch_miss: hit %b idx %0d expected 0 0", resp_hit, resp_index);
        end
        issue(3'd1, 4'd5, '0, 0, 0, 0, lat);
        n_chk++;
        if (lat != 2 || resp_entry !== a || resp_index !== 4'd5) begin
            n_fail++;
            $display("FAIL rd_data: lat %0d entry %h idx %0d expected 2 %h 5", lat, resp_entry, resp_index, a);
        end
    endtask

    task automatic test_multihit();
        int lat;
        issue(3'd2, 4'd9, mk(1, 1, 21, 10'd7, {9'h048, 10'h2AB}), 0, 0, 0, lat);
        issue(3'd0, 0, '0, 0, 10'd3, 19'h12345, lat);
        n_chk++;
        if (resp_hit !== 1'b1 || resp_index !== 4'd5) begin
            n_fail++;
            $display("FAIL multihit_lowest: hit %b idx %0d expected 1 5", resp_hit, resp_index);
        end
        issue(3'd2, 4'd5, '0, 0, 0, 0, lat);
        issue(3'd0, 0, '0, 0, 10'd3, {9'h048, 10'h111}, lat);
        n_chk++;
        if (resp_hit !== 1'b1 || resp_index !== 4'd9) begin
            n_fail++;
            $display("FAIL hugepage_hit: hit %b idx %0d expected 1 9", resp_hit, resp_index);
        end
    endtask

    task automatic test_fill();
        int lat, prev, wraps;
        tlb_entry_t f;
        prev = -1;
        wraps = 0;
        for (int n = 0; n < 16; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            f = mk(1, $urandom_range(0, 1), 12, 10'($urandom_range(1, 3)), 19'($urandom));
            issue(3'd3, 4'($urandom), f, 0, 0, 0, lat);
            n_chk++;
            if (lat != 2 || we_cnt - we0 != 1 || w_idx !== 4'(fill_at) || w_ent !== f) begin
                n_fail++;
                $display("FAIL fill_index: lat %0d we %0d idx %0d expected 2 1 %0d", lat, we_cnt - we0, w_idx, fill_at);
            end
            n_chk++;
            if (int'(w_idx) == prev) begin
                n_fail++;
                $display("FAIL fill_distinct: idx %0d repeats previous %0d", w_idx, prev);
            end
            if (prev >= 0 && int'(w_idx) < prev) wraps++;
            prev = int'(w_idx);
        end
        n_chk++;
        if (wraps == 0) begin
            n_fail++;
            $display("FAIL fill_wrap: got %0d wraps expected at least 1", wraps);
        end
    endtask

    task automatic test_inv();
        int lat;
        tlb_inv_req_t e;
        issue(3'd2, 4'd9, '0, 0, 0, 0, lat);
        issue(3'd2, 4'd5, mk(1, 0, 12, 10'd3, 19'h12345), 0, 0, 0, lat);
        issue(3'd4, 0, '0, 5'd5, 10'd3, 19'h12345, lat);
        e = '{clr_global: 0, clr_nonglobal: 1, check_asid: 1, check_vpn: 1, asid: 10'd3, vpn: 19'h12345};
        n_chk++;
        if (lat != 2 || inv_cnt - inv0 != 1 || we_cnt != we0 || inv_last !== e) begin
            n_fail++;
            $display("FAIL inv_op5: lat %0d inv %0d we %0d req %h expected 2 1 0 %h", lat, inv_cnt - inv0, we_cnt - we0, inv_last, e);
        end
        issue(3'd0, 0, '0, 0, 10'd3, 19'h12345, lat);
        n_chk++;
        if (resp_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_then_srch: hit %b expected 0", resp_hit);
        end
        issue(3'd4, 0, '0, 5'd2, 10'd9, 19'h00777, lat);
        e = '{clr_global: 1, clr_nonglobal: 0, check_asid: 0, check_vpn: 0, asid: 10'd9, vpn: 19'h00777};
        n_chk++;
        if (inv_cnt - inv0 != 1 || inv_last !== e || resp_bad_op !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_op2: inv %0d req %h bad %b expected 1 %h 0", inv_cnt - inv0, inv_last, resp_bad_op, e);
        end
        issue(3'd4, 0, '0, 5'd7, 10'd3, 19'h12345, lat);
        n_chk++;
        if (inv_cnt != inv0 || we_cnt != we0 || resp_bad_op !== 1'b1) begin
            n_fail++;
            $display("FAIL inv_op7: inv %0d we %0d bad %b expected 0 0 1", inv_cnt - inv0, we_cnt - we0, resp_bad_op);
        end
    endtask

    task automatic test_illegal();
        int lat;
        issue(3'd0, 0, '0, 0, 10'd1, 19'h0, lat);
        n_chk++;
        if (resp_bad_op !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_cleared: bad %b expected 0", resp_bad_op);
        end
        issue(3'd6, 4'd2, mk(1, 0, 12, 1, 1), 5'd0, 10'd1, 19'h1, lat);
        n_chk++;
        if (resp_bad_op !== 1'b1 || inv_cnt != inv0 || we_cnt != we0) begin
            n_fail++;
            $display("FAIL illegal_op: bad %b we %0d inv %0d expected 1 0 0", resp_bad_op, we_cnt - we0, inv_cnt - inv0);
        end
    endtask

    task automatic test_abort();
        tlb_entry_t old, c;
        int rv0;
        old = mem[3];
        c = mk(1, 1, 12, 10'd5, 19'h7ABCD);
        @(negedge clk);
        req_op = 3'd2; req_index = 4'd3; req_entry = c; req_valid = 1'b1;
        we0 = we_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (tlb_we !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_in_write: we %b expected 1 before reset", tlb_we);
        end
        rv0 = rv_cnt;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (tlb_we !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_we_drop: we %b expected 0", tlb_we);
        end
        @(negedge clk);
        n_chk++;
        if (tlb_we !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: we %b ready %b rv %b expected 0 1 0", tlb_we, req_ready, resp_valid);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_chk++;
        if (rv_cnt != rv0 || we_cnt != we0 || mem[3] !== old) begin
            n_fail++;
            $display("FAIL abort_no_effect: rv %0d we %0d entry %h expected 0 0 %h", rv_cnt - rv0, we_cnt - we0, mem[3], old);
        end
    endtask

    task automatic test_random();
        int lat, sel;
        logic [2:0] op;
        logic [3:0] idx;
        logic [4:0] iop;
        logic [9:0] asid;
        logic [18:0] vpn;
        logic eh;
        logic [3:0] ei;
        tlb_entry_t ent, er;
        tlb_inv_req_t einv;
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            op = sel < 3 ? 3'd0 : sel < 5 ? 3'd1 : sel < 7 ? 3'd2 : sel < 8 ? 3'd3 : 3'd4;
            idx = 4'($urandom);
            iop = 5'($urandom_range(0, 5));
            asid = 10'($urandom_range(1, 3));
            vpn = {9'($urandom_range(9'h048, 9'h049)), $urandom_range(0, 1) ? 10'h345 : 10'h111};
            ent = mk($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) ? 6'd12 : 6'd21,
                     10'($urandom_range(1, 3)),
                     {9'($urandom_range(9'h048, 9'h049)), $urandom_range(0, 1) ? 10'h345 : 10'h111});
            ref_search(asid, vpn, eh, ei);
            er = mem[idx];
            einv = exp_inv(iop, asid, vpn);
            issue(op, idx, ent, iop, asid, vpn, lat);
            n_chk++;
            if (lat != 2 || resp_bad_op !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_latency: op %0d lat %0d bad %b expected 2 0", op, lat, resp_bad_op);
            end
            n_chk++;
            case (op)
                3'd0: if (resp_hit !== eh || resp_index !== ei) begin
                    n_fail++;
                    $display("FAIL rand_srch: hit %b idx %0d expected %b %0d", resp_hit, resp_index, eh, ei);
                end
                3'd1: if (resp_entry !== er || resp_index !== idx) begin
                    n_fail++;
                    $display("FAIL rand_rd: entry %h idx %0d expected %h %0d", resp_entry, resp_index, er, idx);
                end
                3'd2, 3'd3: if (we_cnt - we0 != 1 || w_ent !== ent || w_idx !== (op == 3'd3 ? 4'(fill_at) : idx)) begin
                    n_fail++;
                    $display("FAIL rand_write: op %0d idx %0d we %0d expected idx %0d", op, w_idx, we_cnt - we0, op == 3'd3 ? 4'(fill_at) : idx);
                end
                default: if (inv_cnt - inv0 != 1 || inv_last !== einv || we_cnt != we0) begin
                    n_fail++;
                    $display("FAIL rand_inv: op %0d req %h expected %h", iop, inv_last, einv);
                end
            endcase
        end
        n_chk++;
        if (both_cnt != 0) begin
            n_fail++;
            $display("FAIL we_inv_overlap: got %0d cycles expected 0", both_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_wr_srch();
        test_multihit();
        test_fill();
        test_inv();
        test_illegal();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
